// File: rtl/cpu_pkg.sv
// rtl/cpu_pkg.sv - shared opcode/phase types and opcode width for the cpu controller
package cpu_pkg;

    localparam int OPCODE_W = 3;

    typedef enum logic [2:0] {
        OP_HLT = 3'd0,
        OP_SKZ = 3'd1,
        OP_ADD = 3'd2,
        OP_AND = 3'd3,
        OP_XOR = 3'd4,
        OP_LDA = 3'd5,
        OP_STO = 3'd6,
        OP_JMP = 3'd7
    } opcode_t;

    typedef enum logic [2:0] {
        PH_INST_ADDR  = 3'd0,
        PH_INST_FETCH = 3'd1,
        PH_INST_LOAD  = 3'd2,
        PH_IDLE       = 3'd3,
        PH_OP_ADDR    = 3'd4,
        PH_OP_FETCH   = 3'd5,
        PH_ALU_OP     = 3'd6,
        PH_STORE      = 3'd7
    } phase_t;

    // Opcodes that read an operand from memory and load the accumulator
    function automatic logic is_aluop(opcode_t op);
        return (op == OP_ADD) || (op == OP_AND) || (op == OP_XOR) || (op == OP_LDA);
    endfunction

endpackage

// File: rtl/phase_counter.sv
// rtl/phase_counter.sv - 8-phase instruction cycle counter with hold and wrap
module phase_counter (
    input  logic       clk,
    input  logic       rst_,
    input  logic       enable,
    output logic [2:0] phase
);

    // Advance one phase per enabled clock; STORE (7) wraps naturally to INST_ADDR (0)
    always_ff @(posedge clk or negedge rst_) begin
        if (!rst_) begin
            phase <= 3'd0;
        end else if (enable) begin
            phase <= phase + 3'd1;
        end
    end

endmodule

// File: rtl/cpu_controller.sv
// rtl/cpu_controller.sv - phase-sequenced control decode; optional sticky halt via CTRL_HALT_LATCH_EN
module cpu_controller #(
    parameter int OPCODE_W = cpu_pkg::OPCODE_W
) (
    input  logic                clk,
    input  logic                rst_,
    input  logic                enable,
    input  logic [OPCODE_W-1:0] opcode,
    input  logic                zero,
    output logic                sel,
    output logic                rd,
    output logic                ld_ir,
    output logic                inc_pc,
    output logic                halt,
    output logic                ld_pc,
    output logic                data_e,
    output logic                ld_ac,
    output logic                wr,
    output logic [2:0]          phase
);

    import cpu_pkg::*;

    opcode_t op;
    phase_t  ph;
    logic    aluop;
    logic    halt_now;
    logic    halt_flag;
    logic    cnt_en;

    assign op       = opcode_t'(opcode);
    assign ph       = phase_t'(phase);
    assign aluop    = is_aluop(op);
    assign halt_now = (ph == PH_OP_ADDR) && (op == OP_HLT);

`ifdef CTRL_HALT_LATCH_EN
    // Sticky halt: once HLT is seen in OP_ADDR, freeze there until reset
    always_ff @(posedge clk or negedge rst_) begin
        if (!rst_) begin
            halt_flag <= 1'b0;
        end else if (halt_now) begin
            halt_flag <= 1'b1;
        end
    end

    // The freeze must already apply on the edge that sets the flag
    assign cnt_en = enable & ~(halt_flag | halt_now);
`else
    assign halt_flag = 1'b0;
    assign cnt_en    = enable;
`endif

    phase_counter u_phase_counter (
        .clk    (clk),
        .rst_   (rst_),
        .enable (cnt_en),
        .phase  (phase)
    );

    // Zero-latency decode of controls from the current phase, opcode and zero flag
    always_comb begin
        sel    = 1'b0;
        rd     = 1'b0;
        ld_ir  = 1'b0;
        inc_pc = 1'b0;
        halt   = halt_flag;
        ld_pc  = 1'b0;
        data_e = 1'b0;
        ld_ac  = 1'b0;
        wr     = 1'b0;
        unique case (ph)
            PH_INST_ADDR: begin
                sel = 1'b1;
            end
            PH_INST_FETCH: begin
                sel = 1'b1;
                rd  = 1'b1;
            end
            PH_INST_LOAD, PH_IDLE: begin
                sel   = 1'b1;
                rd    = 1'b1;
                ld_ir = 1'b1;
            end
            PH_OP_ADDR: begin
                inc_pc = 1'b1;
                halt   = halt_flag | halt_now;
            end
            PH_OP_FETCH: begin
                rd = aluop;
            end
            PH_ALU_OP: begin
                rd     = aluop;
                inc_pc = (op == OP_SKZ) && zero;
                ld_pc  = (op == OP_JMP);
                data_e = (op == OP_STO);
            end
            PH_STORE: begin
                rd     = aluop;
                ld_ac  = aluop;
                ld_pc  = (op == OP_JMP);
                wr     = (op == OP_STO);
                data_e = (op == OP_STO);
            end
            default: begin
            end
        endcase
    end

endmodule

// File: tb/tb_cpu_controller.sv
// tb/tb_cpu_controller.sv - directed bench with a behavioural phase/control model for cpu_controller
module tb_cpu_controller;

`ifdef CTRL_HALT_LATCH_EN
    localparam bit LATCH = 1'b1;
`else
    localparam bit LATCH = 1'b0;
`endif

    logic       clk = 1'b0;
    logic       rst_ = 1'b1;
    logic       enable = 1'b0;
    logic [2:0] opcode = 3'd0;
    logic       zero = 1'b0;
    logic       sel, rd, ld_ir, inc_pc, halt, ld_pc, data_e, ld_ac, wr;
    logic [2:0] phase;

    int vectors = 0;
    int miscompares = 0;

    int m_phase = 0;
    bit m_halted = 1'b0;

    cpu_controller #(.OPCODE_W(3)) dut (
        .clk    (clk),
        .rst_   (rst_),
        .enable (enable),
        .opcode (opcode),
        .zero   (zero),
        .sel    (sel),
        .rd     (rd),
        .ld_ir  (ld_ir),
        .inc_pc (inc_pc),
        .halt   (halt),
        .ld_pc  (ld_pc),
        .data_e (data_e),
        .ld_ac  (ld_ac),
        .wr     (wr),
        .phase  (phase)
    );

    always #5 clk = ~clk;

    // Behavioural model: phase is a mod-8 counter, halt may freeze it in phase 4
    always @(posedge clk or negedge rst_) begin
        if (!rst_) begin
            m_phase  = 0;
            m_halted = 1'b0;
        end else begin
            if (LATCH && m_phase == 4 && opcode == 3'd0) m_halted = 1'b1;
            if (enable && !m_halted) m_phase = (m_phase + 1) % 8;
        end
    end

    // Expected controls as set rules over phase number and opcode class
    function automatic logic [8:0] expect_outs(int p, int op, bit z, bit halted);
        bit aluop;
        bit e_sel, e_rd, e_ld_ir, e_inc, e_halt, e_ld_pc, e_de, e_ld_ac, e_wr;
        aluop   = (op >= 2 && op <= 5);
        e_sel   = (p <= 3);
        e_rd    = (p >= 1 && p <= 3) || (p >= 5 && aluop);
        e_ld_ir = (p == 2 || p == 3);
        e_inc   = (p == 4) || (p == 6 && op == 1 && z);
        e_halt  = (p == 4 && op == 0) || halted;
        e_ld_pc = (p >= 6 && op == 7);
        e_de    = (p >= 6 && op == 6);
        e_ld_ac = (p == 7 && aluop);
        e_wr    = (p == 7 && op == 6);
        return {e_sel, e_rd, e_ld_ir, e_inc, e_halt, e_ld_pc, e_de, e_ld_ac, e_wr};
    endfunction

    // Every-cycle compare of DUT against the model, away from the active edge
    always @(negedge clk) begin
        logic [8:0] exp_o;
        logic [8:0] act_o;
        exp_o = expect_outs(m_phase, int'(opcode), zero, m_halted);
        act_o = {sel, rd, ld_ir, inc_pc, halt, ld_pc, data_e, ld_ac, wr};
        vectors++;
        if (int'(phase) != m_phase) begin
            miscompares++;
            $display("FAIL model_phase t=%0t actual=%0d expected=%0d", $time, phase, m_phase);
        end
        vectors++;
        if (act_o !== exp_o) begin
            miscompares++;
            $display("FAIL model_outs t=%0t phase=%0d op=%0d actual=%b expected=%b (sel rd ld_ir inc_pc halt ld_pc data_e ld_ac wr)",
                     $time, m_phase, opcode, act_o, exp_o);
        end
    end

    task automatic chk(string name, int act, int exp);
        vectors++;
        if (act != exp) begin
            miscompares++;
            $display("FAIL %s t=%0t actual=%0d expected=%0d", name, $time, act, exp);
        end
    endtask

    task automatic at_neg();
        @(negedge clk);
        #1;
    endtask

    // Reset with the given opcode presented; returns at negedge+1 with phase 0 and enable=1
    task automatic restart(logic [2:0] op, logic z);
        at_neg();
        rst_   = 1'b0;
        enable = 1'b1;
        opcode = op;
        zero   = z;
        at_neg();
        chk("reset_sel", int'(sel), 1);
        chk("reset_others", int'({rd, ld_ir, inc_pc, halt, ld_pc, data_e, ld_ac, wr}), 0);
        chk("reset_phase", int'(phase), 0);
        rst_ = 1'b1;
    endtask

    initial begin
        #1 rst_ = 1'b0;

        // ADD walk: phases 0..7 then 0
        restart(3'd2, 1'b0);
        for (int i = 0; i <= 8; i++) begin
            chk($sformatf("add_phase%0d", i), int'(phase), i % 8);
            chk($sformatf("add_rd%0d", i), int'(rd), int'((i % 8) inside {1, 2, 3, 5, 6, 7}));
            chk($sformatf("add_ld_ac%0d", i), int'(ld_ac), int'(i == 7));
            at_neg();
        end

        // STO: data_e in 6-7, wr only in 7, rd low in 5-7
        restart(3'd6, 1'b0);
        for (int i = 0; i < 8; i++) begin
            chk($sformatf("sto_data_e%0d", i), int'(data_e), int'(i >= 6));
            chk($sformatf("sto_wr%0d", i), int'(wr), int'(i == 7));
            if (i >= 5) chk($sformatf("sto_rd%0d", i), int'(rd), 0);
            at_neg();
        end

        // SKZ with zero=1 then zero=0
        restart(3'd1, 1'b1);
        for (int i = 0; i < 8; i++) begin
            chk($sformatf("skz1_inc_pc%0d", i), int'(inc_pc), int'(i == 4 || i == 6));
            at_neg();
        end
        restart(3'd1, 1'b0);
        for (int i = 0; i < 8; i++) begin
            chk($sformatf("skz0_inc_pc%0d", i), int'(inc_pc), int'(i == 4));
            at_neg();
        end

        // HLT behaviour depends on the build option
        restart(3'd0, 1'b0);
        for (int i = 0; i < 4; i++) at_neg();
        chk("hlt_at_op_addr_phase", int'(phase), 4);
        chk("hlt_at_op_addr_halt", int'(halt), 1);
        if (LATCH) begin
            for (int i = 0; i < 10; i++) begin
                at_neg();
                chk($sformatf("hlt_stuck_phase%0d", i), int'(phase), 4);
                chk($sformatf("hlt_stuck_halt%0d", i), int'(halt), 1);
            end
        end else begin
            at_neg();
            chk("hlt_pulse_phase", int'(phase), 5);
            chk("hlt_pulse_halt", int'(halt), 0);
        end

        // Async reset in STORE with STO: wr drops and phase clears without a clock edge
        restart(3'd6, 1'b0);
        for (int i = 0; i < 7; i++) at_neg();
        chk("abort_pre_phase", int'(phase), 7);
        chk("abort_pre_wr", int'(wr), 1);
        #1 rst_ = 1'b0;
        #1;
        chk("abort_wr", int'(wr), 0);
        chk("abort_phase", int'(phase), 0);
        chk("abort_sel", int'(sel), 1);
        at_neg();
        chk("abort_still_no_wr", int'(wr), 0);
        rst_ = 1'b1;

        // Hold with enable=0 after advancing to phase 2
        opcode = 3'd2;
        at_neg();
        at_neg();
        chk("hold_start_phase", int'(phase), 2);
        enable = 1'b0;
        for (int i = 0; i < 3; i++) begin
            at_neg();
            chk($sformatf("hold_phase%0d", i), int'(phase), 2);
        end
        enable = 1'b1;
        at_neg();
        chk("hold_resume_phase", int'(phase), 3);

        at_neg();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

    initial begin
        #100000;
        $display("FAIL watchdog t=%0t actual=timeout expected=finish", $time);
        $fatal(1, "watchdog");
    end

endmodule
